// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Bundle between the control/register-file side and the sequential ALU.
//   start     request, sampled by the ALU only while busy=0
//   ctrl      4-bit operation code, captured with start
//   busA/busB operands, captured with start
//   busW      registered result, held until the next accepted start
//   zero/negative/carry/overflow  NZCV flags belonging to busW
//   busy      multi-cycle operation in progress
//   done      one-cycle pulse: busW and flags valid for the op just finished
// Modports: master = issuing side, slave = ALU.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic [WIDTH-1:0] busW;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ctrl, busA, busB,
        input  busW, zero, negative, carry, overflow, busy, done
    );

    modport slave (
        input  start, ctrl, busA, busB,
        output busW, zero, negative, carry, overflow, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked, registered ALU: AND/ORR/ADD/SUB/PASS/LSL/LSR complete in one
// cycle, MUL runs a WIDTH-step shift-add loop. Every result lands in busW
// together with full NZCV flags and a one-cycle done pulse.
// Ports:
//   CLK    clock, all state changes on the rising edge
//   Reset  synchronous, active-high reset (wins over start)
//   bus    alu_seq_if.slave: start/ctrl/busA/busB in,
//          busW/zero/negative/carry/overflow/busy/done out
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic       CLK,
    input  logic       Reset,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LSL = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PAS = 4'b0111;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } aluOut_t;

    // Shared adder: SUB is A + ~B + 1, so carry means "no borrow".
    function automatic aluOut_t addSub(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             sub);
        aluOut_t          o;
        logic [WIDTH-1:0] bOp;
        logic [WIDTH:0]   s;
        bOp   = sub ? ~b : b;
        s     = {1'b0, a} + {1'b0, bOp} + {{WIDTH{1'b0}}, sub};
        o.res = s[WIDTH-1:0];
        o.c   = s[WIDTH];
        o.v   = (a[WIDTH-1] == bOp[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]);
        return o;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   stepCnt;

    aluOut_t          opOut;
    logic [WIDTH-1:0] accNext;

    // Single-cycle result straight from the operand buses.
    always_comb begin
        opOut = '0;
        case (bus.ctrl)
            OP_AND: opOut.res = bus.busA & bus.busB;
            OP_ORR: opOut.res = bus.busA | bus.busB;
            OP_ADD: opOut     = addSub(bus.busA, bus.busB, 1'b0);
            OP_SUB: opOut     = addSub(bus.busA, bus.busB, 1'b1);
            OP_PAS: opOut.res = bus.busB;
            OP_LSL: opOut.res = bus.busA << bus.busB[SHW-1:0];
            OP_LSR: opOut.res = bus.busA >> bus.busB[SHW-1:0];
            default: opOut    = '0;
        endcase
    end

    // One shift-add step; the final step's sum goes straight to busW.
    always_comb begin
        accNext = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= IDLE;
            bus.busW     <= '0;
            bus.zero     <= 1'b1;
            bus.negative <= 1'b0;
            bus.carry    <= 1'b0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            stepCnt      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ctrl == OP_MUL) begin
                            mcand    <= bus.busA;
                            mplier   <= bus.busB;
                            acc      <= '0;
                            stepCnt  <= '0;
                            bus.busy <= 1'b1;
                            state    <= MUL;
                        end else begin
                            bus.busW     <= opOut.res;
                            bus.zero     <= (opOut.res == '0);
                            bus.negative <= opOut.res[WIDTH-1];
                            bus.carry    <= opOut.c;
                            bus.overflow <= opOut.v;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc     <= accNext;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    stepCnt <= stepCnt + 1'b1;
                    // No early exit: always WIDTH steps, data-independent latency.
                    if (stepCnt == LAST_STEP) begin
                        bus.busW     <= accNext;
                        bus.zero     <= (accNext == '0);
                        bus.negative <= accNext[WIDTH-1];
                        bus.carry    <= 1'b0;
                        bus.overflow <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=64): accepted operations push the
// reference result into a queue; a monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int W = 64;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LSL = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PAS = 4'b0111;

    localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINS = -MAXS - 66'sd1;

    typedef struct packed {
        logic [W-1:0] w;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;
    exp_t sbq[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: arithmetic on wide signed/unsigned values, not bit tricks.
    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t                  e;
        logic [W:0]            wide;
        logic signed [65:0]    sa;
        logic signed [65:0]    sb;
        logic signed [65:0]    sr;
        e  = '0;
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        case (op)
            OP_AND: e.w = a & b;
            OP_ORR: e.w = a | b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                e.w  = wide[W-1:0];
                e.c  = wide[W];
                sr   = sa + sb;
                e.v  = (sr > MAXS) || (sr < MINS);
            end
            OP_SUB: begin
                e.w = a - b;
                e.c = (a >= b);
                sr  = sa - sb;
                e.v = (sr > MAXS) || (sr < MINS);
            end
            OP_PAS: e.w = b;
            OP_LSL: e.w = a << (b % W);
            OP_LSR: e.w = a >> (b % W);
            OP_MUL: e.w = a * b;
            default: e.w = '0;
        endcase
        e.z = (e.w == '0);
        e.n = e.w[W-1];
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents one op for one edge; the ALU accepts it only if idle.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.ctrl  = op;
        bus.busA  = a;
        bus.busB  = b;
        if (!bus.busy && !Reset) sbq.push_back(model(op, a, b));
        step();
        bus.start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL waitIdle actual=busy required=idle within 200 cycles");
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!Reset && bus.done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=done required=no_done busW=%h", bus.busW);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_busW", bus.busW, e.w);
                chk("sb_nzcv", {60'd0, bus.zero, bus.negative, bus.carry, bus.overflow},
                    {60'd0, e.z, e.n, e.c, e.v});
            end
        end
    end

    initial begin
        logic [W-1:0] held;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        bus.start = 1'b0;
        bus.ctrl  = 4'h0;
        bus.busA  = '0;
        bus.busB  = '0;
        repeat (3) step();

        // Reset state
        chk("rst_busW", bus.busW, '0);
        chk("rst_flags", {60'd0, bus.zero, bus.negative, bus.carry, bus.overflow}, 64'h8);
        chk("rst_busy_done", {62'd0, bus.busy, bus.done}, '0);
        Reset = 1'b0;
        step();

        // 1: ADD, one-cycle latency, then held
        issue(OP_ADD, 64'h82C639269A, 64'h82C639269A);
        chk("t1_done", {63'd0, bus.done}, 64'd1);
        chk("t1_busW", bus.busW, 64'h1058C724D34);
        step();
        chk("t1_done_low", {63'd0, bus.done}, 64'd0);
        chk("t1_hold", bus.busW, 64'h1058C724D34);

        // 2, 3: SUB equal, ADD signed overflow, SUB borrow
        issue(OP_SUB, 64'h7F0C4B3F, 64'h7F0C4B3F);
        issue(OP_ADD, 64'h7FFFFFFFFFFFFFFF, 64'd1);
        issue(OP_SUB, 64'd0, 64'd1);
        step();

        // 4: MUL latency, ignored starts, back-to-back ORR
        held = bus.busW;
        issue(OP_MUL, 64'h12345, 64'h10);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            chk("t4_held", bus.busW, held);
            issue(OP_PAS, 64'd0, {$urandom, $urandom});
        end
        chk("t4_busy_cycles", 64'(n), 64'd64);
        chk("t4_done", {63'd0, bus.done}, 64'd1);
        chk("t4_busW", bus.busW, 64'h123450);
        issue(OP_ORR, 64'hF0, 64'h0F);
        chk("t4_orr_done", {63'd0, bus.done}, 64'd1);
        chk("t4_orr_busW", bus.busW, 64'hFF);
        step();

        // 5: shifts with masked amount, undefined op code
        issue(OP_LSL, 64'd1, 64'd63);
        issue(OP_LSR, 64'h8000000000000000, 64'd65);
        chk("t5_lsr", bus.busW, 64'h4000000000000000);
        issue(4'hF, 64'hDEAD, 64'hBEEF);
        chk("t5_undef", bus.busW, '0);
        step();

        // 6: reset aborts MUL
        issue(OP_MUL, 64'h1234567, 64'h89ABCDEF);
        repeat (9) step();
        Reset = 1'b1;
        sbq.delete();
        step();
        chk("t6_busy_done", {62'd0, bus.busy, bus.done}, '0);
        chk("t6_busW", bus.busW, '0);
        chk("t6_zero", {63'd0, bus.zero}, 64'd1);
        Reset = 1'b0;
        issue(OP_ADD, 64'd1, 64'd1);
        chk("t6_add", bus.busW, 64'd2);
        step();

        // Randomized traffic, including edge operands
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: a = 64'h7FFFFFFFFFFFFFFF;
                1: b = 64'h8000000000000000;
                2: b = '1;
                3: a = '0;
                default: ;
            endcase
            issue(op, a, b);
            if (bus.busy) waitIdle();
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
